// File: rtl/fifo_sum_sched.sv
// Frame scheduler in front of the three-row column-sum datapath: grants one
// requester per frame round-robin, paces bytes as pi_flag pulses, tags results.
module fifo_sum_sched #(
    parameter int COLS = 4,
    parameter int ROWS = 5,
    parameter int GAP  = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       pi_flag,
    output logic [7:0] pi_data,
    input  logic       po_flag,
    input  logic [7:0] po_data,
    output logic       res_flag,
    output logic [7:0] res_data,
    output logic       res_id,
    output logic       frame_done,
    output logic       busy,
    output logic       err_orphan
);

    localparam logic [7:0] IN_TOTAL  = 8'(ROWS * COLS);
    localparam logic [7:0] OUT_TOTAL = 8'((ROWS - 2) * COLS);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);

    typedef enum logic [1:0] {IDLE, GRANT, STREAM, DRAIN} state_t;

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic [7:0] in_cnt;
    logic [7:0] out_cnt;
    logic [7:0] gap_cnt;

    // Ready/valid: ready is decoded from registered state only and never looks
    // at valid; a byte moves on any cycle where both are high at the clock edge.
    logic       stream_ok;
    logic       xfer;
    logic [7:0] xfer_data;
    logic       po_live;
    logic       po_accept;
    logic       last_result;

    assign stream_ok   = (state == STREAM) && (gap_cnt == 8'd0) && (in_cnt < IN_TOTAL);
    assign req0_ready  = stream_ok && !owner;
    assign req1_ready  = stream_ok && owner;
    assign xfer        = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    assign xfer_data   = owner ? req1_data : req0_data;
    assign po_live     = (state == STREAM) || (state == DRAIN);
    assign po_accept   = po_flag && po_live && (out_cnt != OUT_TOTAL);
    assign last_result = po_accept && (out_cnt == OUT_TOTAL - 8'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            in_cnt     <= 8'd0;
            out_cnt    <= 8'd0;
            gap_cnt    <= 8'd0;
            pi_flag    <= 1'b0;
            pi_data    <= 8'd0;
            res_flag   <= 1'b0;
            res_data   <= 8'd0;
            res_id     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            pi_flag    <= xfer;
            res_flag   <= po_accept;
            frame_done <= last_result;
            busy       <= (state != IDLE);

            if (xfer) begin
                pi_data <= xfer_data;
                in_cnt  <= in_cnt + 8'd1;
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end

            // Results outside a live frame, or beyond its count, are dropped.
            if (po_accept) begin
                res_data <= po_data;
                res_id   <= owner;
                out_cnt  <= out_cnt + 8'd1;
            end else if (po_flag) begin
                err_orphan <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) state <= GRANT;
                end
                GRANT: begin
                    in_cnt  <= 8'd0;
                    out_cnt <= 8'd0;
                    // A requester that withdrew before the grant returns us to IDLE.
                    if (req0_valid && req1_valid) begin
                        owner <= ~last_owner;
                        state <= STREAM;
                    end else if (req0_valid || req1_valid) begin
                        owner <= req1_valid;
                        state <= STREAM;
                    end else begin
                        state <= IDLE;
                    end
                end
                STREAM: begin
                    if (xfer && (in_cnt == IN_TOTAL - 8'd1)) state <= DRAIN;
                end
                DRAIN: begin
                    if (last_result) begin
                        state      <= IDLE;
                        last_owner <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_sum_sched.md
# fifo_sum_sched

Frame scheduler and arbiter in front of the three-row FIFO column-sum datapath (`fifo_sum_ctrl`). Two byte-stream requesters compete for the datapath. The block grants one requester per whole frame, round-robin, and paces bytes into the datapath as single-cycle `pi_flag` pulses with held `pi_data`. It collects the datapath's `po_flag`/`po_data` results, tags each with the owning requester, and signals frame completion before re-arbitrating.

## Interface
Parameters:
- `COLS`, default 4: columns per row. The datapath column limit must equal COLS-1.
- `ROWS`, default 5: rows per frame. The datapath row limit must equal ROWS-1. Minimum value is 3.
- `GAP`, default 4: minimum cycles between successive `pi_flag` pulses. Minimum value is 3.

Ports:
- `sys_clk`, in, 1: the only clock.
- `sys_rst_n`, in, 1: asynchronous, active-low reset.
- `req0_valid`, in, 1; `req0_data`, in, 8; `req0_ready`, out, 1: requester 0 byte stream.
- `req1_valid`, in, 1; `req1_data`, in, 8; `req1_ready`, out, 1: requester 1 byte stream.
- `pi_flag`, out, 1: one-cycle strobe of a new byte to the datapath.
- `pi_data`, out, 8: byte to the datapath. Held until the next `pi_flag`.
- `po_flag`, in, 1: datapath result strobe.
- `po_data`, in, 8: datapath result (column sum mod 256).
- `res_flag`, out, 1: tagged result strobe.
- `res_data`, out, 8: tagged result value.
- `res_id`, out, 1: requester that owns the result.
- `frame_done`, out, 1: one-cycle pulse on the last result of a frame.
- `busy`, out, 1: high in every state except IDLE.
- `err_orphan`, out, 1: sticky flag. Set when `po_flag` arrives outside STREAM or DRAIN, or arrives after the frame's result count is already reached.

## Operation
- Per-frame totals:
  - IN_TOTAL = ROWS*COLS bytes in.
  - OUT_TOTAL = (ROWS-2)*COLS results out.
  - Counters are 8 bits wide. ROWS*COLS must be ≤ 255.
- States: IDLE, GRANT, STREAM, DRAIN.
- **IDLE**
  - Go to GRANT when any `reqN_valid` is high.
  - `busy` is 0.
- **GRANT** (one cycle)
  - Latch `owner`.
  - If only one requester is valid, grant that one.
  - If both are valid, grant the requester that is not `last_owner`.
  - `last_owner` resets to 1, so requester 0 wins the first tie.
  - Clear `in_cnt` and `out_cnt`, then go to STREAM.
- **STREAM**
  - `reqN_ready` = (N == owner) && `gap_cnt` == 0 && `in_cnt` < IN_TOTAL.
  - Ready is decoded from registered state only and never depends on valid.
  - The non-owner's ready is always 0.
  - A transfer occurs when valid && ready.
  - A requester that drops valid mid-frame stalls the stream. There is no timeout and no abort.
  - When `in_cnt` reaches IN_TOTAL, go to DRAIN.
- **DRAIN**
  - Wait for `out_cnt` == OUT_TOTAL.
  - On the final result, go to IDLE and set `last_owner` = `owner`.
- Result path:
  - In STREAM and DRAIN, each `po_flag` increments `out_cnt` and is forwarded.
  - `po_flag` while `out_cnt` == OUT_TOTAL is dropped and sets `err_orphan`.
  - `po_flag` in IDLE or GRANT is dropped and sets `err_orphan`.
  - `err_orphan` clears only on reset.
- Arithmetic: no widening. `res_data` is `po_data` passed through unchanged, mod 256.
- Reset mid-frame: every register returns to its reset value. The datapath shares `sys_rst_n`, so both sides resynchronise together. A partial frame is discarded without `frame_done`.

## Timing
- Reset values:
  - `pi_flag`, `pi_data`, `res_flag`, `res_data`, `res_id`, `frame_done`, `busy`, `err_orphan`, `req0_ready`, `req1_ready` are all 0.
  - `gap_cnt` = 0, state = IDLE.
- Valid high in IDLE at cycle t: GRANT at t+1. STREAM at t+2, with ready able to assert at t+2.
- Transfer at cycle c:
  - `pi_flag` = 1 and `pi_data` = data at c+1.
  - `gap_cnt` is loaded with GAP-1 at c+1 and decrements to 0.
  - Next transfer is at c+GAP at the earliest, so `pi_flag` pulses are ≥ GAP cycles apart.
- `pi_data` stays stable from c+1 through at least c+3, as the datapath requires it when it forms the sum.
- Result latency:
  - The datapath asserts `po_flag` 3 cycles after `pi_flag`.
  - `res_flag`/`res_data`/`res_id` are registered: one cycle after `po_flag`, i.e. c+5 after the transfer.
- `frame_done` asserts in the same cycle as the `res_flag` carrying result OUT_TOTAL. `busy` falls the following cycle.
- Back-to-back frames: a minimum of 2 idle cycles (IDLE, GRANT) between the last `res_flag` of one frame and the first ready of the next.

## Test plan
- Single frame, 5×4 defaults: req0 sends values 1..20 row-major, valid always high.
  - Expect 20 `pi_flag` pulses spaced exactly 4 cycles.
  - Expect `res_data` = 15,18,21,24,27,30,33,36,39,42,45,48, all with `res_id` 0.
  - Expect `frame_done` on the 12th result, and `err_orphan` 0.
- Both requesters valid from reset:
  - Requester 0 is granted first; `req1_ready` stays 0 throughout its frame.
  - Requester 1 is granted next, with results tagged `res_id` 1.
  - req0 is granted again only after req1's `frame_done`.
- Wrap: a frame of all 0xFF bytes gives 12 results of 0xFD.
- Stall: requester 0 drops valid for 10 cycles after byte 7.
  - `pi_flag` gap stretches accordingly.
  - Results stay identical to the first scenario.
  - No `pi_flag` is issued without a transfer.
- Reset mid-frame after byte 9: all outputs return to 0 and state to IDLE with no `frame_done`. A fresh frame then produces the correct results.
- Orphan: inject `po_flag` while in IDLE → `err_orphan` becomes 1, `res_flag` stays 0, and the flag stays set until reset.
